// File: rtl/matmul_stream.sv
// rtl/matmul_stream.sv - sequential signed matrix multiply with streamed C output
module matmul_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_DIM    = 256,
  parameter int DIM_W      = $clog2(MAX_DIM) + 1,
  parameter int IDX_W      = $clog2(MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_W-1:0]      dim_n,
  input  logic [DIM_W-1:0]      dim_m,
  input  logic [DIM_W-1:0]      dim_j,
  input  logic [DIM_W-1:0]      dim_k,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  a_rd_en,
  output logic [2*IDX_W-1:0]    a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_rd_data,
  output logic                  b_rd_en,
  output logic [2*IDX_W-1:0]    b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [ACC_WIDTH-1:0]  c_data,
  output logic [IDX_W-1:0]      c_row,
  output logic [IDX_W-1:0]      c_col,
  output logic                  c_last
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MAC, S_OUT, S_FIN} state_t;

  localparam logic [DIM_W-1:0] LP_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] LP_ONE = DIM_W'(1);

  state_t                        r_state;
  state_t                        w_next;
  logic [DIM_W-1:0]              r_n, r_m, r_j, r_k;
  logic [IDX_W-1:0]              r_i, r_kc;
  // r_p counts read cycles 0..m-1, then m marks the cycle the last product lands
  logic [DIM_W-1:0]              r_p;
  logic                          r_err;
  logic                          r_pend;
  logic [ACC_WIDTH-1:0]          r_acc;

  logic                          w_illegal;
  logic                          w_issue;
  logic                          w_row_last;
  logic                          w_col_last;
  logic                          w_accept;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]          w_prod_ext;

  assign w_illegal  = (r_n == '0) || (r_m == '0) || (r_j == '0) || (r_k == '0) ||
                      (r_n > LP_MAX) || (r_m > LP_MAX) || (r_j > LP_MAX) || (r_k > LP_MAX) ||
                      (r_m != r_j);
  assign w_issue    = (r_state == S_MAC) && (r_p < r_m);
  assign w_row_last = ({1'b0, r_i} == (r_n - LP_ONE));
  assign w_col_last = ({1'b0, r_kc} == (r_k - LP_ONE));
  assign w_accept   = (r_state == S_OUT) && c_ready;
  assign w_prod     = $signed(a_rd_data) * $signed(b_rd_data);
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  assign a_rd_en   = w_issue;
  assign b_rd_en   = w_issue;
  assign a_rd_addr = w_issue ? {r_i, r_p[IDX_W-1:0]}  : '0;
  assign b_rd_addr = w_issue ? {r_p[IDX_W-1:0], r_kc} : '0;
  assign c_data    = c_valid ? r_acc : '0;
  assign c_row     = c_valid ? r_i   : '0;
  assign c_col     = c_valid ? r_kc  : '0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and status/handshake outputs
  always_comb begin
    w_next  = r_state;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    c_valid = 1'b0;
    c_last  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: begin
        busy   = 1'b1;
        w_next = w_illegal ? S_FIN : S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (r_p == r_m) w_next = S_OUT;
      end
      S_OUT: begin
        busy    = 1'b1;
        c_valid = 1'b1;
        c_last  = w_row_last && w_col_last;
        if (c_ready) w_next = (w_row_last && w_col_last) ? S_FIN : S_MAC;
      end
      S_FIN: begin
        done   = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Dimension latch, element/read counters and accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n    <= '0;
      r_m    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_i    <= '0;
      r_kc   <= '0;
      r_p    <= '0;
      r_err  <= 1'b0;
      r_pend <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_pend <= w_issue;
      if (r_state == S_IDLE && start) begin
        r_n <= dim_n;
        r_m <= dim_m;
        r_j <= dim_j;
        r_k <= dim_k;
      end
      if (r_state == S_CHECK) begin
        r_err <= w_illegal;
        r_i   <= '0;
        r_kc  <= '0;
        r_p   <= '0;
      end
      if (w_issue) r_p <= r_p + LP_ONE;
      if (w_accept) begin
        r_p <= '0;
        if (w_col_last) begin
          r_kc <= '0;
          r_i  <= r_i + IDX_W'(1);
        end else begin
          r_kc <= r_kc + IDX_W'(1);
        end
      end
      // Products arrive one cycle after their read; the first read of an element restarts the sum
      if (w_issue && r_p == '0) r_acc <= '0;
      else if (r_pend)          r_acc <= r_acc + w_prod_ext;
    end
  end

endmodule

// File: tb/tb_matmul_stream.sv
// tb/tb_matmul_stream.sv - randomized self-checking bench for matmul_stream
module tb_matmul_stream;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int MD = 256;
  localparam int DIM_W = 9;
  localparam int IDX_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [DIM_W-1:0] dim_n = '0, dim_m = '0, dim_j = '0, dim_k = '0;
  logic busy, done, err;
  logic a_rd_en, b_rd_en;
  logic [2*IDX_W-1:0] a_rd_addr, b_rd_addr;
  logic [DW-1:0] a_rd_data = '0, b_rd_data = '0;
  logic c_valid;
  logic c_ready = 1'b0;
  logic [AW-1:0] c_data;
  logic [IDX_W-1:0] c_row, c_col;
  logic c_last;

  matmul_stream #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_DIM(MD)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dim_n(dim_n), .dim_m(dim_m), .dim_j(dim_j), .dim_k(dim_k),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .c_row(c_row), .c_col(c_col), .c_last(c_last)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] a_mem [0:MD*MD-1];
  logic signed [DW-1:0] b_mem [0:MD*MD-1];

  // Row-major buffers with one-cycle read latency; garbage when not strobed
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    else         a_rd_data <= DW'($urandom);
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    else         b_rd_data <= DW'($urandom);
  end

  typedef struct {
    logic [AW-1:0] data;
    int row;
    int col;
    bit last;
    int rel;
  } elem_t;

  elem_t got[$];
  int rises[$];
  logic [AW-1:0] exp_q[$];
  int first_read, reads, done_rel, done_cnt, err_cnt, viol, valid_cnt;
  bit busy1, busy_at_done, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic fill_random(input int n, input int m, input int k);
    for (int r = 0; r < n; r++) for (int c = 0; c < m; c++) a_mem[r*MD+c] = DW'($urandom);
    for (int r = 0; r < m; r++) for (int c = 0; c < k; c++) b_mem[r*MD+c] = DW'($urandom);
  endtask

  task automatic fill_const(input int n, input int m, input int k, input int av, input int bv);
    for (int r = 0; r < n; r++) for (int c = 0; c < m; c++) a_mem[r*MD+c] = DW'(av);
    for (int r = 0; r < m; r++) for (int c = 0; c < k; c++) b_mem[r*MD+c] = DW'(bv);
  endtask

  // Reference: plain dot products, row-major order, wrapped to the result width
  task automatic model(input int n, input int m, input int k);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int kk = 0; kk < k; kk++) begin
        longint s = 0;
        for (int p = 0; p < m; p++) s += longint'(a_mem[i*MD+p]) * longint'(b_mem[p*MD+kk]);
        exp_q.push_back(AW'(s));
      end
  endtask

  // Launches one job and records what the DUT does, relative to the start cycle
  task automatic run_job(input int n, input int m, input int j, input int k,
                         input int ready_pct, input int hold, input int budget);
    bit prev_valid, prev_stall;
    elem_t pe;
    int hold_left;
    got.delete();
    rises.delete();
    first_read = -1; reads = 0; done_rel = -1; done_cnt = 0; err_cnt = 0;
    viol = 0; valid_cnt = 0; busy1 = 0; busy_at_done = 0; timeout = 0;
    prev_valid = 0; prev_stall = 0; hold_left = hold;
    pe = '{data: '0, row: 0, col: 0, last: 0, rel: 0};
    @(negedge clk);
    dim_n = DIM_W'(n); dim_m = DIM_W'(m); dim_j = DIM_W'(j); dim_k = DIM_W'(k);
    start = 1'b1;
    c_ready = 1'b0;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      start = 1'b0;
      dim_n = DIM_W'($urandom); dim_m = DIM_W'($urandom);
      dim_j = DIM_W'($urandom); dim_k = DIM_W'($urandom);
      if (c_valid && hold_left > 0) begin
        c_ready = 1'b0;
        hold_left--;
      end else begin
        c_ready = ($urandom_range(99) < ready_pct);
      end
      if (rel == 1) busy1 = busy;
      if (prev_stall && !(c_valid && c_data === pe.data && int'(c_row) == pe.row &&
                          int'(c_col) == pe.col && c_last == pe.last)) viol++;
      if (c_valid && (a_rd_en || b_rd_en)) viol++;
      if (a_rd_en != b_rd_en) viol++;
      if (!a_rd_en && a_rd_addr != '0) viol++;
      if (!b_rd_en && b_rd_addr != '0) viol++;
      if (err && !done) viol++;
      if (a_rd_en) begin
        reads++;
        if (first_read < 0) first_read = rel;
      end
      if (c_valid) valid_cnt++;
      if (c_valid && !prev_valid) rises.push_back(rel);
      if (c_valid && c_ready)
        got.push_back('{data: c_data, row: int'(c_row), col: int'(c_col), last: c_last, rel: rel});
      if (done) begin
        done_rel = rel;
        done_cnt++;
        if (err) err_cnt++;
        busy_at_done = busy;
        break;
      end
      prev_valid = c_valid;
      prev_stall = c_valid && !c_ready;
      pe = '{data: c_data, row: int'(c_row), col: int'(c_col), last: c_last, rel: rel};
    end
    if (done_rel < 0) timeout = 1;
  endtask

  task automatic test_reset;
    logic [94:0] obs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, c_valid, c_data, c_row, c_col, c_last};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    a_mem[0] = 16'sd5;
    b_mem[0] = -16'sd3;
    run_job(1, 1, 1, 1, 100, 0, 50);
    n_cmp++;
    if (got.size() != 1 || timeout) begin
      n_bad++;
      $display("FAIL single_count: got %0d elements timeout=%0d required 1", got.size(), timeout);
    end else begin
      n_cmp++;
      if (got[0].data !== AW'(-15) || got[0].row != 0 || got[0].col != 0 || got[0].last != 1'b1) begin
        n_bad++;
        $display("FAIL single_elem: got %0d (%0d,%0d) last=%0d required -15 (0,0) last=1",
                 $signed(got[0].data), got[0].row, got[0].col, got[0].last);
      end
      n_cmp++;
      if (got[0].rel != 4 || first_read != 2) begin
        n_bad++;
        $display("FAIL single_latency: got valid T+%0d read T+%0d required T+4 T+2", got[0].rel, first_read);
      end
    end
    n_cmp++;
    if (done_rel != 5 || err_cnt != 0 || busy1 != 1'b1 || busy_at_done != 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got done T+%0d err=%0d busy1=%0d busy@done=%0d required T+5 0 1 0",
               done_rel, err_cnt, busy1, busy_at_done);
    end
  endtask

  task automatic test_2x2;
    int want [4] = '{19, 22, 43, 50};
    int want_rise [4] = '{5, 9, 13, 17};
    fill_const(0, 0, 0, 0, 0);
    a_mem[0] = 1; a_mem[1] = 2; a_mem[MD] = 3; a_mem[MD+1] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[MD] = 7; b_mem[MD+1] = 8;
    run_job(2, 2, 2, 2, 100, 0, 60);
    n_cmp++;
    if (got.size() != 4 || rises.size() != 4) begin
      n_bad++;
      $display("FAIL 2x2_count: got %0d elements %0d rises required 4 4", got.size(), rises.size());
    end else begin
      for (int e = 0; e < 4; e++) begin
        n_cmp++;
        if (got[e].data !== AW'(want[e]) || got[e].row != e/2 || got[e].col != e%2 ||
            got[e].last != (e == 3) || rises[e] != want_rise[e]) begin
          n_bad++;
          $display("FAIL 2x2_elem%0d: got %0d (%0d,%0d) last=%0d rise T+%0d required %0d (%0d,%0d) last=%0d rise T+%0d",
                   e, $signed(got[e].data), got[e].row, got[e].col, got[e].last, rises[e],
                   want[e], e/2, e%2, (e == 3), want_rise[e]);
        end
      end
    end
    n_cmp++;
    if (done_rel != 18 || err_cnt != 0 || viol != 0) begin
      n_bad++;
      $display("FAIL 2x2_done: got T+%0d err=%0d viol=%0d required T+18 0 0", done_rel, err_cnt, viol);
    end
  endtask

  task automatic test_illegal;
    int dims [3][4] = '{'{100, 100, 50, 50}, '{0, 4, 4, 4}, '{4, 4, 4, 257}};
    for (int t = 0; t < 3; t++) begin
      run_job(dims[t][0], dims[t][1], dims[t][2], dims[t][3], 100, 0, 20);
      n_cmp++;
      if (done_rel != 2 || err_cnt != 1 || reads != 0 || valid_cnt != 0 || viol != 0) begin
        n_bad++;
        $display("FAIL illegal%0d: got done T+%0d err=%0d reads=%0d valids=%0d viol=%0d required T+2 1 0 0 0",
                 t, done_rel, err_cnt, reads, valid_cnt, viol);
      end
    end
  endtask

  task automatic test_backpressure;
    int want [4] = '{19, 22, 43, 50};
    a_mem[0] = 1; a_mem[1] = 2; a_mem[MD] = 3; a_mem[MD+1] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[MD] = 7; b_mem[MD+1] = 8;
    run_job(2, 2, 2, 2, 100, 5, 80);
    n_cmp++;
    if (got.size() != 4 || viol != 0 || timeout) begin
      n_bad++;
      $display("FAIL bp_count: got %0d elements viol=%0d timeout=%0d required 4 0 0", got.size(), viol, timeout);
    end else begin
      n_cmp++;
      if (got[0].rel != 10) begin
        n_bad++;
        $display("FAIL bp_first_accept: got T+%0d required T+10", got[0].rel);
      end
      for (int e = 0; e < 4; e++) begin
        n_cmp++;
        if (got[e].data !== AW'(want[e]) || got[e].last != (e == 3)) begin
          n_bad++;
          $display("FAIL bp_elem%0d: got %0d last=%0d required %0d last=%0d",
                   e, $signed(got[e].data), got[e].last, want[e], (e == 3));
        end
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(1, 5);
      int m = $urandom_range(1, 5);
      int k = $urandom_range(1, 5);
      fill_random(n, m, k);
      model(n, m, k);
      run_job(n, m, m, k, 60, 0, n*k*(m+2)*6 + 60);
      n_cmp++;
      if (got.size() != exp_q.size() || done_cnt != 1 || err_cnt != 0 || viol != 0) begin
        n_bad++;
        $display("FAIL rand%0d_job: got %0d elems done=%0d err=%0d viol=%0d required %0d 1 0 0",
                 t, got.size(), done_cnt, err_cnt, viol, exp_q.size());
      end else begin
        for (int e = 0; e < got.size(); e++) begin
          n_cmp++;
          if (got[e].data !== exp_q[e] || got[e].row != e/k || got[e].col != e%k ||
              got[e].last != (e == got.size()-1)) begin
            n_bad++;
            $display("FAIL rand%0d_elem%0d: got %0d (%0d,%0d) last=%0d required %0d (%0d,%0d)",
                     t, e, $signed(got[e].data), got[e].row, got[e].col, got[e].last,
                     $signed(exp_q[e]), e/k, e%k);
          end
        end
      end
    end
  endtask

  task automatic test_boundary;
    int dims [3][3] = '{'{2, 256, 2}, '{256, 1, 2}, '{2, 1, 256}};
    for (int t = 0; t < 3; t++) begin
      int n = dims[t][0];
      int m = dims[t][1];
      int k = dims[t][2];
      int bad = 0;
      if (t == 0) fill_const(n, m, k, 32767, 32767);
      else        fill_random(n, m, k);
      model(n, m, k);
      run_job(n, m, m, k, 100, 0, n*k*(m+2) + 60);
      if (t == 0) begin
        n_cmp++;
        if (exp_q.size() != 4 || exp_q[0] !== AW'(64'd274861129984)) begin
          n_bad++;
          $display("FAIL bound_model: got %0d required 274861129984", exp_q[0]);
        end
      end
      n_cmp++;
      if (got.size() != n*k || done_cnt != 1 || err_cnt != 0 || viol != 0) begin
        n_bad++;
        $display("FAIL bound%0d_job: got %0d elems done=%0d err=%0d viol=%0d required %0d 1 0 0",
                 t, got.size(), done_cnt, err_cnt, viol, n*k);
      end else begin
        for (int e = 0; e < got.size(); e++)
          if (got[e].data !== exp_q[e] || got[e].row != e/k || got[e].col != e%k ||
              got[e].last != (e == got.size()-1)) bad++;
        n_cmp++;
        if (bad != 0) begin
          n_bad++;
          $display("FAIL bound%0d_elems: got %0d wrong elements required 0", t, bad);
        end
        n_cmp++;
        if (got[n*k-1].row != n-1 || got[n*k-1].col != k-1 || got[n*k-1].last != 1'b1) begin
          n_bad++;
          $display("FAIL bound%0d_last: got (%0d,%0d) last=%0d required (%0d,%0d) 1",
                   t, got[n*k-1].row, got[n*k-1].col, got[n*k-1].last, n-1, k-1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_job;
    logic [94:0] obs;
    int dones = 0;
    int valids = 0;
    fill_random(4, 4, 4);
    @(negedge clk);
    dim_n = 4; dim_m = 4; dim_j = 4; dim_k = 4;
    start = 1'b1;
    c_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    obs = {busy, done, err, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, c_valid, c_data, c_row, c_col, c_last};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h required 0", obs);
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
      if (c_valid) valids++;
    end
    n_cmp++;
    if (dones != 0 || valids != 0) begin
      n_bad++;
      $display("FAIL midreset_quiet: got done=%0d valid=%0d required 0 0", dones, valids);
    end
    a_mem[0] = 16'sd2;
    b_mem[0] = 16'sd3;
    run_job(1, 1, 1, 1, 100, 0, 50);
    n_cmp++;
    if (got.size() != 1 || got[0].data !== AW'(6) || err_cnt != 0) begin
      n_bad++;
      $display("FAIL midreset_next: got %0d elems first=%0d err=%0d required 1 6 0",
               got.size(), (got.size() > 0) ? $signed(got[0].data) : -1, err_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_2x2;
    test_illegal;
    test_backpressure;
    test_random;
    test_boundary;
    test_reset_mid_job;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_stream.md
Name: matmul_stream

Overview:
Sequential signed matrix-multiply engine, the next generation of the team's fixed-size matmul. Computes C = A x B with dimensions set at runtime, up to MAX_DIM. Operands are fetched through two synchronous read ports from external row-major buffers. C is streamed out element by element on a valid/ready interface. Illegal dimension combinations are reported as errors instead of producing output.

Parameters:
DATA_WIDTH, 16, signed operand width.
ACC_WIDTH, 40, signed accumulator/result width; must be at least 2*DATA_WIDTH + log2(MAX_DIM).
MAX_DIM, 256, maximum of every dimension; power of two.
DIM_W, $clog2(MAX_DIM)+1, width of dimension inputs (holds the value MAX_DIM).
IDX_W, $clog2(MAX_DIM), row/column index width.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  launch request; sampled only in IDLE.
dim_n  in  DIM_W  rows of A.
dim_m  in  DIM_W  columns of A.
dim_j  in  DIM_W  rows of B.
dim_k  in  DIM_W  columns of B.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at job end (success or error).
err  out  1  one-cycle pulse, coincident with done, on an illegal job.
a_rd_en  out  1  A read strobe.
a_rd_addr  out  2*IDX_W  {row, col} of A.
a_rd_data  in  DATA_WIDTH  A data; valid exactly 1 cycle after a_rd_en.
b_rd_en  out  1  B read strobe.
b_rd_addr  out  2*IDX_W  {row, col} of B.
b_rd_data  in  DATA_WIDTH  B data; valid exactly 1 cycle after b_rd_en.
c_valid  out  1  result element available.
c_ready  in  1  consumer accepts when c_valid && c_ready.
c_data  out  ACC_WIDTH  signed C[i][k].
c_row  out  IDX_W  i of the current element.
c_col  out  IDX_W  k of the current element.
c_last  out  1  high with the final element, C[n-1][k-1].

Behaviour:
- Reset: state IDLE. All outputs are 0. Accumulator and counters are cleared. Any in-flight job is discarded with no done pulse.
- FSM: IDLE -> CHECK -> MAC -> OUT -> (MAC | FIN) -> IDLE. On an illegal job, CHECK -> FIN with err.
- IDLE: when start=1, latch dim_n/m/j/k and go to CHECK; busy rises the next cycle.
- start is ignored in every state other than IDLE. Dimension inputs are don't-care after they are latched.
- CHECK (1 cycle), illegal job if any of:
  - any dimension is 0;
  - any dimension is greater than MAX_DIM;
  - dim_m != dim_j.
- Illegal job response: no reads issued, no c_valid; done=err=1 for 1 cycle, then IDLE.
- MAC for element (i,k): issue m read cycles, p = 0..m-1, with a_rd_en = b_rd_en = 1, a_rd_addr = {i,p}, b_rd_addr = {p,k}.
- Accumulation: each returned product is sign-extended to ACC_WIDTH and added to the accumulator one cycle after its read. The accumulator is cleared at the first read of each element. Arithmetic wraps modulo 2^ACC_WIDTH.
- OUT: c_valid rises on cycle m+1, counting the first read cycle as 0. c_data, c_row, c_col and c_last hold stable while c_valid && !c_ready.
- On acceptance: c_valid drops the next cycle and reads for the next element start that same cycle. Cadence is m+2 cycles per element with c_ready held high.
- Element order: row-major (k fastest, then i).
- Timing: a start sampled at cycle T gives the first read at T+2 and the first c_valid at T+m+3.
- FIN: done=1 for 1 cycle in the cycle after the c_last handshake; busy falls in that same cycle. The FSM is in IDLE the cycle after, and a new start is accepted there.
- Read strobes are 0 outside MAC issue cycles. Addresses are 0 when the strobes are 0.

Test Plan:
- 1x1*1x1, A=5, B=-3, c_ready=1 -> single c_data=-15 with c_valid at T+4, c_row=c_col=0, c_last=1; done one cycle after the handshake; err=0.
- 2x2*2x2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> stream 19, 22, 43, 50 at (0,0), (0,1), (1,0), (1,1); c_last only on 50; consecutive c_valid rises 4 cycles apart.
- 100x100*50x50 -> err=done=1 at T+2, no a_rd_en/b_rd_en and no c_valid ever. Repeat with dim_n=0 and with dim_k=257 -> same response.
- Backpressure on 2x2: hold c_ready=0 for 5 cycles while c_valid=1 -> c_data=19 stable, no new reads; release -> remaining 22, 43, 50 correct.
- 256x256 with all A=B=32767 -> every c_data=274861129984 with no wrap; exactly 65536 elements; last at (255,255) with c_last=1.
- Reset asserted mid-MAC of a 4x4 job -> next cycle all outputs 0 and no done pulse; a following 1x1 job (A=2, B=3) -> 6.
